// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - Knight's Tour command sequencer; optional landing sponge bit under TOUR_SPONGE_EN
module tour_cmd_seq #(
   parameter int         NUM_MOVES  = 24,
   parameter bit         VERT_FIRST = 1'b1,
   parameter logic [7:0] HDG_N      = 8'h00,
   parameter logic [7:0] HDG_S      = 8'h7F,
   parameter logic [7:0] HDG_W      = 8'h3F,
   parameter logic [7:0] HDG_E      = 8'hBF,
   localparam int        IDX_W      = $clog2(NUM_MOVES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_tour,
   input  logic [7:0]       move,
   output logic [IDX_W-1:0] mv_indx,
   input  logic [15:0]      cmd_UART,
   input  logic             cmd_rdy_UART,
   output logic [15:0]      cmd,
   output logic             cmd_rdy,
   input  logic             clr_cmd_rdy,
   input  logic             send_resp,
   output logic [7:0]       resp
);

   typedef enum logic [2:0] {IDLE, FETCH, LEG_A, WAIT_A, LEG_B, WAIT_B, ERR} state_t;

`ifdef TOUR_SPONGE_EN
   localparam logic SPONGE_B = 1'b1;
`else
   localparam logic SPONGE_B = 1'b0;
`endif

   state_t      state, state_nxt;
   logic [15:0] leg_a, leg_b;
   logic        err_flag;
   logic        tour_rdy;
   logic        one_hot;
   logic        last_move;
   logic [7:0]  v_hdg, h_hdg;
   logic [3:0]  v_sq, h_sq;
   logic [15:0] v_cmd, h_cmd;

   assign one_hot   = (move != 8'd0) && ((move & (move - 8'd1)) == 8'd0);
   assign last_move = (mv_indx == IDX_W'(NUM_MOVES - 1));

   // Leg decode assumes a one-hot move; illegal entries never reach the leg registers.
   always_comb begin
      v_hdg = HDG_N;
      v_sq  = 4'd0;
      h_hdg = HDG_E;
      h_sq  = 4'd0;
      if (move[0] | move[1]) begin
         v_hdg = HDG_N; v_sq = 4'd2;
      end else if (move[2] | move[7]) begin
         v_hdg = HDG_N; v_sq = 4'd1;
      end else if (move[3] | move[6]) begin
         v_hdg = HDG_S; v_sq = 4'd1;
      end else if (move[4] | move[5]) begin
         v_hdg = HDG_S; v_sq = 4'd2;
      end
      if (move[0] | move[5]) begin
         h_hdg = HDG_E; h_sq = 4'd1;
      end else if (move[1] | move[4]) begin
         h_hdg = HDG_W; h_sq = 4'd1;
      end else if (move[2] | move[3]) begin
         h_hdg = HDG_W; h_sq = 4'd2;
      end else if (move[6] | move[7]) begin
         h_hdg = HDG_E; h_sq = 4'd2;
      end
   end

   assign v_cmd = {3'b010, 1'b0, v_hdg, v_sq};
   assign h_cmd = {3'b010, 1'b0, h_hdg, h_sq};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tour_rdy  = 1'b0;
      case (state)
         IDLE:   if (start_tour) state_nxt = FETCH;
         FETCH:  state_nxt = one_hot ? LEG_A : ERR;
         LEG_A: begin
            tour_rdy = 1'b1;
            if (clr_cmd_rdy) state_nxt = WAIT_A;
         end
         WAIT_A: if (send_resp) state_nxt = LEG_B;
         LEG_B: begin
            tour_rdy = 1'b1;
            if (clr_cmd_rdy) state_nxt = WAIT_B;
         end
         WAIT_B: if (send_resp) state_nxt = last_move ? IDLE : FETCH;
         ERR:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mv_indx  <= '0;
         err_flag <= 1'b0;
         leg_a    <= 16'd0;
         leg_b    <= 16'd0;
      end else begin
         if (state == IDLE && start_tour) begin
            mv_indx  <= '0;
            err_flag <= 1'b0;
         end
         if (state == FETCH) begin
            if (one_hot) begin
               if (VERT_FIRST) begin
                  leg_a <= v_cmd;
                  leg_b <= h_cmd | {3'b000, SPONGE_B, 12'd0};
               end else begin
                  leg_a <= h_cmd;
                  leg_b <= v_cmd | {3'b000, SPONGE_B, 12'd0};
               end
            end else begin
               err_flag <= 1'b1;
            end
         end
         if (state == WAIT_B && send_resp && !last_move)
            mv_indx <= mv_indx + 1'b1;
      end
   end

   // Error status is sticky in IDLE so the host can read it after the abort.
   always_comb begin
      cmd     = leg_a;
      cmd_rdy = tour_rdy;
      resp    = 8'h5A;
      case (state)
         IDLE: begin
            cmd     = cmd_UART;
            cmd_rdy = cmd_rdy_UART;
            resp    = err_flag ? 8'hEE : 8'hA5;
         end
         LEG_B, WAIT_B: cmd  = leg_b;
         ERR:           resp = 8'hEE;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - directed/random bench for tour_cmd_seq against a displacement-based move model
module tb_tour_cmd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_tour   [2];
   logic        cmd_rdy_uart [2];
   logic        cmd_rdy      [2];
   logic        clr          [2];
   logic        send_resp    [2];
   logic [7:0]  move         [2];
   logic [7:0]  resp         [2];
   logic [15:0] cmd_uart     [2];
   logic [15:0] cmd          [2];
   logic [4:0]  mv_indx0;
   logic [0:0]  mv_indx1;
   logic [7:0]  store0 [24];
   logic [7:0]  store1 [2];

   int errors = 0;
   int checks = 0;
   int nm [2] = '{24, 2};
   bit vf [2] = '{1'b1, 1'b0};
   // Knight displacement per one-hot bit: +dy is north, +dx is east.
   int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
   int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};

   assign move[0] = store0[mv_indx0];
   assign move[1] = store1[mv_indx1];

   tour_cmd_seq #(.NUM_MOVES(24), .VERT_FIRST(1'b1)) u_dut0 (
      .clk(clk), .rst(rst), .start_tour(start_tour[0]), .move(move[0]), .mv_indx(mv_indx0),
      .cmd_UART(cmd_uart[0]), .cmd_rdy_UART(cmd_rdy_uart[0]), .cmd(cmd[0]), .cmd_rdy(cmd_rdy[0]),
      .clr_cmd_rdy(clr[0]), .send_resp(send_resp[0]), .resp(resp[0]));

   tour_cmd_seq #(.NUM_MOVES(2), .VERT_FIRST(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .start_tour(start_tour[1]), .move(move[1]), .mv_indx(mv_indx1),
      .cmd_UART(cmd_uart[1]), .cmd_rdy_UART(cmd_rdy_uart[1]), .cmd(cmd[1]), .cmd_rdy(cmd_rdy[1]),
      .clr_cmd_rdy(clr[1]), .send_resp(send_resp[1]), .resp(resp[1]));

   initial forever #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int idx(input int d);
      return (d == 0) ? int'(mv_indx0) : int'(mv_indx1);
   endfunction

   function automatic logic [7:0] st(input int d, input int k);
      return (d == 0) ? store0[k] : store1[k];
   endfunction

   function automatic logic [15:0] leg(input int d, input logic [7:0] m, input bit second);
      int b = 0;
      bit vert;
      bit sp;
      logic [7:0] hdg;
      int sq;
      for (int i = 0; i < 8; i++) if (m[i]) b = i;
      vert = second ? !vf[d] : vf[d];
      if (vert) begin
         hdg = (dy_t[b] > 0) ? 8'h00 : 8'h7F;
         sq  = (dy_t[b] > 0) ? dy_t[b] : -dy_t[b];
      end else begin
         hdg = (dx_t[b] > 0) ? 8'hBF : 8'h3F;
         sq  = (dx_t[b] > 0) ? dx_t[b] : -dx_t[b];
      end
`ifdef TOUR_SPONGE_EN
      sp = second;
`else
      sp = 1'b0;
`endif
      return {3'b010, sp, hdg, 4'(sq)};
   endfunction

   task automatic fill_random(input int d);
      for (int k = 0; k < nm[d]; k++) begin
         if (d == 0) store0[k] = 8'h01 << $urandom_range(7, 0);
         else        store1[k] = 8'h01 << $urandom_range(7, 0);
      end
   endtask

   // Runs a tour on dut d; abort_at >= 0 asserts rst while in WAIT_B of that move.
   task automatic tour(input int d, input int abort_at);
      logic [15:0] exp_cmd;
      start_tour[d] = 1'b1;
      tick();
      start_tour[d] = 1'b0;
      for (int k = 0; k < nm[d]; k++) begin
         chk("fetch_resp", 16'(resp[d]), 16'h005A);
         chk("fetch_rdy", 16'(cmd_rdy[d]), 16'h0000);
         chk("fetch_idx", 16'(idx(d)), 16'(k));
         tick();
         for (int l = 0; l < 2; l++) begin
            exp_cmd = leg(d, st(d, k), l[0]);
            chk("leg_rdy", 16'(cmd_rdy[d]), 16'h0001);
            chk("leg_cmd", cmd[d], exp_cmd);
            for (int h = $urandom_range(2, 0); h > 0; h--) begin
               send_resp[d] = 1'($urandom_range(1, 0));
               cmd_rdy_uart[d] = 1'($urandom_range(1, 0));
               tick();
               send_resp[d] = 1'b0;
               chk("leg_hold_rdy", 16'(cmd_rdy[d]), 16'h0001);
               chk("leg_hold_cmd", cmd[d], exp_cmd);
            end
            clr[d] = 1'b1;
            send_resp[d] = 1'($urandom_range(1, 0));
            tick();
            clr[d] = 1'b0;
            send_resp[d] = 1'b0;
            chk("wait_rdy", 16'(cmd_rdy[d]), 16'h0000);
            chk("wait_resp", 16'(resp[d]), 16'h005A);
            for (int w = $urandom_range(2, 0); w > 0; w--) begin
               clr[d] = 1'($urandom_range(1, 0));
               start_tour[d] = 1'($urandom_range(1, 0));
               cmd_rdy_uart[d] = 1'b1;
               tick();
               clr[d] = 1'b0;
               start_tour[d] = 1'b0;
               chk("wait_hold_rdy", 16'(cmd_rdy[d]), 16'h0000);
               chk("wait_hold_idx", 16'(idx(d)), 16'(k));
            end
            if (l == 1 && k == abort_at) begin
               cmd_rdy_uart[d] = 1'b1;
               rst = 1'b1;
               tick();
               rst = 1'b0;
               chk("rst_idx", 16'(idx(d)), 16'h0000);
               chk("rst_resp", 16'(resp[d]), 16'h00A5);
               chk("rst_rdy", 16'(cmd_rdy[d]), 16'h0001);
               return;
            end
            send_resp[d] = 1'b1;
            tick();
            send_resp[d] = 1'b0;
         end
      end
      cmd_rdy_uart[d] = 1'($urandom_range(1, 0));
      cmd_uart[d] = 16'($urandom);
      #1;
      chk("done_resp", 16'(resp[d]), 16'h00A5);
      chk("done_idx", 16'(idx(d)), 16'(nm[d] - 1));
      chk("done_rdy", 16'(cmd_rdy[d]), 16'(cmd_rdy_uart[d]));
      chk("done_cmd", cmd[d], cmd_uart[d]);
      tick();
      chk("done_idx_hold", 16'(idx(d)), 16'(nm[d] - 1));
   endtask

   task automatic err_run(input int d, input logic [7:0] bad);
      if (d == 0) store0[0] = bad;
      else        store1[0] = bad;
      cmd_rdy_uart[d] = 1'b0;
      start_tour[d] = 1'b1;
      tick();
      start_tour[d] = 1'b0;
      chk("err_fetch_resp", 16'(resp[d]), 16'h005A);
      cmd_rdy_uart[d] = 1'b1;
      tick();
      chk("err_resp", 16'(resp[d]), 16'h00EE);
      chk("err_rdy", 16'(cmd_rdy[d]), 16'h0000);
      cmd_rdy_uart[d] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("err_idle_resp", 16'(resp[d]), 16'h00EE);
         chk("err_idle_rdy", 16'(cmd_rdy[d]), 16'h0000);
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start_tour[d] = 1'b0;
         clr[d] = 1'b0;
         send_resp[d] = 1'b0;
         cmd_uart[d] = 16'($urandom);
         cmd_rdy_uart[d] = (d == 0);
         fill_random(d);
      end
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("reset_resp", 16'(resp[d]), 16'h00A5);
         chk("reset_idx", 16'(idx(d)), 16'h0000);
         chk("reset_rdy", 16'(cmd_rdy[d]), 16'(d == 0));
         chk("reset_cmd", cmd[d], cmd_uart[d]);
      end
      rst = 1'b0;
      tick();

      cmd_uart[0] = 16'h2345;
      cmd_rdy_uart[0] = 1'b1;
      #1;
      chk("pass_cmd", cmd[0], 16'h2345);
      chk("pass_rdy", 16'(cmd_rdy[0]), 16'h0001);
      cmd_rdy_uart[0] = 1'b0;
      #1;
      chk("pass_rdy_low", 16'(cmd_rdy[0]), 16'h0000);
      tick();

      store1[0] = 8'h80;
      store1[1] = 8'h10;
      tour(1, -1);
      tour(0, -1);
      fill_random(0);
      tour(0, 5);
      tick();

      err_run(0, 8'h03);
      fill_random(0);
      tour(0, -1);
      err_run(1, 8'h00);
      fill_random(1);
      tour(1, -1);
      for (int i = 0; i < 3; i++) begin
         fill_random(1);
         tour(1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
